// File: rtl/and_word_serial_tx.sv
// and_word_serial_tx
//   Accepts operand pairs over valid/ready and forms their bitwise AND. The
//   result is parked in a one-entry holding register, then shifted out
//   LSB-first on a 1-bit serial link with valid/ready/last framing.
//   Back-to-back frames abut with no idle bit when the next word is already
//   held at the end of a frame.
//
//   Optional feature macro: AND_SER_PARITY_EN
//     defined   : each frame carries an extra even-parity bit (WIDTH+1 bits),
//                 and ser_last marks that parity bit.
//     undefined : frame is WIDTH bits, and ser_last marks bit WIDTH-1.
module and_word_serial_tx #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef AND_SER_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] hold_q,      hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sr_q,        sr_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
`ifdef AND_SER_PARITY_EN
    logic             par_q,       par_d;
`endif

    logic accept;
    logic load;
    logic frame_done;

    // Next-state logic: operand capture, FSM sequencing and shift-register load.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
`ifdef AND_SER_PARITY_EN
        par_d       = par_q;
`endif
        load        = 1'b0;
        frame_done  = 1'b0;

        // Accept can never coincide with a load: accept needs the hold empty,
        // while a load needs it full.
        accept = in_valid & ~hold_full_q;
        if (accept) begin
            hold_d      = in_a & in_b;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ser_ready) begin
                    if (cnt_q != LAST_IDX) begin
                        sr_d  = sr_q >> 1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
`ifdef AND_SER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        frame_done = 1'b1;
`endif
                    end
                end
            end
`ifdef AND_SER_PARITY_EN
            ST_PARITY: begin
                if (ser_ready) begin
                    frame_done = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // End of frame: chain straight into the held word, otherwise go idle.
        if (frame_done) begin
            if (hold_full_q) begin
                load = 1'b1;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (load) begin
            sr_d        = hold_q;
            hold_full_d = 1'b0;
            cnt_d       = '0;
            state_d     = ST_SHIFT;
`ifdef AND_SER_PARITY_EN
            par_d       = ^hold_q;
`endif
        end
    end

    // State registers with synchronous reset; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sr_q        <= '0;
            cnt_q       <= '0;
`ifdef AND_SER_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
`ifdef AND_SER_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        in_ready  = ~hold_full_q;
        busy      = (state_q != ST_IDLE) | hold_full_q;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        ser_last  = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                ser_valid = 1'b1;
                ser_data  = sr_q[0];
`ifndef AND_SER_PARITY_EN
                ser_last  = (cnt_q == LAST_IDX);
`endif
            end
`ifdef AND_SER_PARITY_EN
            ST_PARITY: begin
                ser_valid = 1'b1;
                ser_data  = par_q;
                ser_last  = 1'b1;
            end
`endif
            default: begin
                ser_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_and_word_serial_tx.sv
// tb_and_word_serial_tx
//   Directed steps followed by a randomized run scored against a queue of
//   expected serial bits. Honours AND_SER_PARITY_EN for frame length.
module tb_and_word_serial_tx;

    localparam int WIDTH = 5;
    localparam int CNT_W = 3;
`ifdef AND_SER_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_data;
    logic             ser_last;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Expected serial stream: {data, last} per bit.
    logic [1:0] sb[$];

    and_word_serial_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_data  (ser_data),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit i of the frame carrying word w: data bits LSB-first, then parity.
    function automatic logic frame_bit(input logic [WIDTH-1:0] w, input int i);
        if (i < WIDTH) return w[i];
        return ^w;
    endfunction

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = 0; i < FLEN; i++)
            sb.push_back({frame_bit(w, i), (i == FLEN - 1) ? 1'b1 : 1'b0});
    endtask

    // Offer one operand pair from idle and follow the whole frame.
    task automatic send_and_expect(input string tag, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] w;
        w = a & b;
        in_valid = 1'b1; in_a = a; in_b = b; ser_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_lat_valid"}, ser_valid, 1'b0);
        check({tag, "_lat_ready"}, in_ready, 1'b0);
        check({tag, "_lat_busy"}, busy, 1'b1);
        tick();
        for (int i = 0; i < FLEN; i++) begin
            check($sformatf("%s_v%0d", tag, i), ser_valid, 1'b1);
            check($sformatf("%s_d%0d", tag, i), ser_data, frame_bit(w, i));
            check($sformatf("%s_l%0d", tag, i), ser_last, (i == FLEN - 1) ? 1'b1 : 1'b0);
            tick();
        end
        check({tag, "_end_valid"}, ser_valid, 1'b0);
        check({tag, "_end_busy"}, busy, 1'b0);
        check({tag, "_end_ready"}, in_ready, 1'b1);
    endtask

    initial begin : main
        logic [WIDTH-1:0] w1, w2, w;
        logic             q_bits[$];
        int               cyc, sent;
        logic [1:0]       head;

        // Step 1: reset with in_valid asserted; nothing may be captured.
        rst = 1'b1; in_valid = 1'b1; in_a = '1; in_b = '1; ser_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_valid", ser_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_data", ser_data, 1'b0);
        check("rst_last", ser_last, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_nocap_valid", ser_valid, 1'b0);
            check("rst_nocap_busy", busy, 1'b0);
        end

        // Step 2: single word 10110 & 11100 = 10100.
        send_and_expect("single", 5'b10110, 5'b11100);

        // Step 3: two words offered back-to-back; frames must abut.
        w1 = 5'b10110 & 5'b11100;
        w2 = 5'b01011;
        q_bits.delete();
        for (int i = 0; i < FLEN; i++) q_bits.push_back(frame_bit(w1, i));
        for (int i = 0; i < FLEN; i++) q_bits.push_back(frame_bit(w2, i));
        in_valid = 1'b1; in_a = 5'b10110; in_b = 5'b11100; ser_ready = 1'b1;
        tick();
        check("b2b_ready0", in_ready, 1'b0);
        in_a = w2; in_b = w2;
        tick();
        for (int i = 0; i < 2 * FLEN; i++) begin
            check($sformatf("b2b_v%0d", i), ser_valid, 1'b1);
            check($sformatf("b2b_d%0d", i), ser_data, q_bits[i]);
            check($sformatf("b2b_l%0d", i), ser_last,
                  ((i == FLEN - 1) || (i == 2 * FLEN - 1)) ? 1'b1 : 1'b0);
            check($sformatf("b2b_r%0d", i), in_ready,
                  ((i == 0) || (i >= FLEN)) ? 1'b1 : 1'b0);
            if (i == 1) in_valid = 1'b0;
            tick();
        end
        check("b2b_end_valid", ser_valid, 1'b0);
        check("b2b_end_busy", busy, 1'b0);

        // Step 4: stall for 3 cycles while bit index 2 is presented.
        w = 5'b10100;
        in_valid = 1'b1; in_a = w; in_b = '1; ser_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < FLEN; i++) begin
            check($sformatf("stall_d%0d", i), ser_data, frame_bit(w, i));
            check($sformatf("stall_l%0d", i), ser_last, (i == FLEN - 1) ? 1'b1 : 1'b0);
            if (i == 2) begin
                ser_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check("stall_hold_v", ser_valid, 1'b1);
                    check("stall_hold_d", ser_data, 1'b1);
                    check("stall_hold_l", ser_last, 1'b0);
                end
                ser_ready = 1'b1;
            end
            tick();
        end
        check("stall_end_valid", ser_valid, 1'b0);

        // Step 5: reset while bit index 3 is presented and a second word is held.
        in_valid = 1'b1; in_a = 5'b10100; in_b = '1; ser_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_a = 5'b11111; in_b = 5'b10101;
        tick();
        in_valid = 1'b0;
        check("midrst_held", in_ready, 1'b0);
        tick();
        tick();
        check("midrst_bit3_v", ser_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", ser_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", in_ready, 1'b1);
        for (int i = 0; i < 2 * FLEN; i++) begin
            tick();
            check("midrst_quiet", ser_valid, 1'b0);
        end

        // Step 6: parity-sensitive words (frame length depends on the macro).
        send_and_expect("par_a", 5'b10100, 5'b11111);
        send_and_expect("par_b", 5'b10101, 5'b11111);

        // Randomized run scored against the expected bit queue.
        sb.delete();
        cyc = 0; sent = 0;
        while ((sent < 40 || sb.size() != 0 || busy) && cyc < 3000) begin
            ser_ready = 1'($urandom_range(0, 3) != 0);
            if (sent < 40) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a = WIDTH'($urandom);
                in_b = WIDTH'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                push_word(in_a & in_b);
                sent++;
            end
            if (ser_valid) begin
                if (sb.size() == 0) begin
                    check("rnd_unexpected_bit", 1'b1, 1'b0);
                end else begin
                    head = sb[0];
                    check("rnd_data", ser_data, head[1]);
                    check("rnd_last", ser_last, head[0]);
                    if (ser_ready) void'(sb.pop_front());
                end
            end
            tick();
            cyc++;
        end
        check("rnd_drain_in_budget", (cyc < 3000) ? 1 : 0, 1);
        check("rnd_queue_empty", sb.size(), 0);
        check("rnd_all_sent", sent, 40);
        check("rnd_idle_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
